dsm2_dac_core: RTL and testbench
================================

Name: dsm2_dac_core

Overview:
- Second-order, single-bit delta-sigma modulator. Consumes signed PCM samples from the sine ROM / sample-source stage and produces the 1-bit oversampled stream that drives the GPIO DAC pin through an external RC filter.
- A valid/ready handshake decouples it from the upstream address/ROM stage.
- An internal oversampling counter sets the sample rate: one new sample every OSR clocks.

Parameters:
- DATA_W, 16, input sample width (signed two's complement, full scale FS = 2^(DATA_W-1)).
- ACC_W, 20, integrator width (must be at least DATA_W+3).
- OSR, 64, clocks per input sample (at least 2).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  modulator enable
- sample_i  in  DATA_W  signed input sample
- sample_valid_i  in  1  sample_i valid
- sample_ready_o  out  1  holding register can accept a sample
- dac_o  out  1  registered 1-bit DAC output
- sample_tick_o  out  1  one-clock pulse when a sample is loaded into the modulator
- underrun_o  out  1  sticky flag: load slot with empty holding register
- sat_o  out  1  sticky flag: an integrator saturated
- clr_flags_i  in  1  synchronous clear of underrun_o and sat_o

Behaviour:
- Reset (async, rst_n=0): all registers 0. Outputs: dac_o=0, sample_ready_o=1, sample_tick_o=0, underrun_o=0, sat_o=0. Counter, integrators and holding register are cleared. Reset mid-stream discards any held sample.
- Holding register (1 entry):
  - Handshake completes when sample_valid_i and sample_ready_o are both high at a rising edge.
  - sample_ready_o = !hold_full OR load_now. This allows accept and consume in the same cycle.
- Oversampling counter:
  - Counts 0..OSR-1 and wraps while en_i=1. load_now = en_i AND (cnt==OSR-1).
  - On load_now with hold_full: x_reg <= hold. sample_tick_o pulses high for the following cycle.
  - On load_now with hold empty: x_reg keeps its value, underrun_o <= 1, and sample_tick_o stays 0.
- Modulator, updated every enabled clock:
  - fb = +FS if dac_o==1, else -FS, sign-extended to ACC_W.
  - i1 <= sat(i1 + x_reg - fb).
  - i2 <= sat(i2 + i1_next - fb), where i1_next is the new i1.
  - dac_o <= (i2_next >= 0).
  - Latency: a change in x_reg affects dac_o one clock later.
- Saturation: clamp to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]. Any clamp sets sat_o.
- Stable input range is |x| ≤ 0.8·FS. Larger inputs are allowed but may saturate.
- en_i=0: counter, integrators, x_reg and dac_o freeze. The handshake still accepts into the holding register.
- Flags: clr_flags_i has priority over setting in the same cycle.

Optional Feature:
- Macro DSM2_DITHER_EN.
- Defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every enabled clock. Its LSB is added as ±1 LSB to the i1 input term to break idle tones.
- Undefined: no LFSR; the behaviour is exactly deterministic as specified above.

Decomposition:
- Package dsm_pkg:
  - DATA_W/ACC_W defaults
  - typedefs sample_t (logic signed [DATA_W-1:0]) and acc_t
  - constant FS
  - function sat_acc()
  - LFSR polynomial and seed constants
- Sub-module dsm_os_counter: oversampling counter generating load_now and honouring en_i.
- Integrators, handshake and flags stay in dsm2_dac_core.

Test Plan:
- Reset/idle: hold rst_n=0 for 99 ns → dac_o=0, sample_ready_o=1, flags 0. Release with no samples → underrun_o=1 after the first OSR=64 clocks.
- Zero input: feed 16'h0000 continuously → over 4096 clocks after settling, ones count = 2048 ±8 and sat_o stays 0.
- Half scale: feed 16'h4000 → ones density 75% ±0.5% over 4096 clocks. sample_tick_o pulses exactly every 64 clocks.
- Handshake:
  - Hold valid high with values 1, 2, 3 … → exactly one accept per 64 clocks.
  - A same-cycle accept and load is observed.
  - No sample is lost or duplicated (checked by a scoreboard on x_reg).
- Overdrive/flags:
  - Feed 16'h7FFF for 2048 clocks → sat_o=1 and ones density > 95%.
  - Pulse clr_flags_i → both flags 0 the next cycle.
- Enable/reset mid-operation:
  - Drop en_i for 100 clocks → dac_o and the counter are frozen.
  - Assert rst_n=0 mid-sample → all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared types, defaults and helpers for the second-order delta-sigma DAC core.
// Optional dither in dsm2_dac_core is enabled by defining DSM2_DITHER_EN.
package dsm_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned OSR_DEF    = 64;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  localparam int FS = 2 ** (DATA_W_DEF - 1);

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Clamp v to a w-bit two's complement range; w is a constant at every call site.
  function automatic logic signed [63:0] sat_acc(input  logic signed [63:0] v,
                                                 input  int unsigned        w,
                                                 output logic               clamped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clamped = 1'b1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    clamped = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/dsm_os_counter.sv
// Oversampling counter: counts 0..OSR-1 while enabled and flags the sample-load slot.
module dsm_os_counter
  import dsm_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic load_now_o
);

  localparam int unsigned CntW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(OSR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max     = (cnt_q == CntMax);
  assign load_now_o = en_i & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsm2_dac_core.sv
// Second-order 1-bit delta-sigma DAC core with a one-entry sample holding register.
// Define DSM2_DITHER_EN to add +/-1 LSB LFSR dither to the first integrator.
module dsm2_dac_core
  import dsm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OSR    = OSR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              dac_o,
  output logic              sample_tick_o,
  output logic              underrun_o,
  output logic              sat_o,
  input  logic              clr_flags_i
);

  // Two guard bits cover i2 + i1 +/- FS before clamping.
  localparam int unsigned SumW = ACC_W + 2;
  localparam logic signed [SumW-1:0] FsVal = SumW'(64'd1 << (DATA_W - 1));
  localparam logic signed [SumW-1:0] One   = SumW'(1);

  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     hold_full_q, hold_full_d;
  logic signed [ACC_W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic                     dac_q, dac_d;
  logic                     tick_q, tick_d;
  logic                     underrun_q, underrun_d;
  logic                     sat_q, sat_d;

  logic                     load_now;
  logic                     accept;
  logic signed [SumW-1:0]   x_ext, fb, dith, i1_sum, i2_sum;
  logic signed [ACC_W-1:0]  i1_n, i2_n;
  logic                     i1_clamp, i2_clamp;

  dsm_os_counter #(
    .OSR (OSR)
  ) u_os_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .load_now_o (load_now)
  );

  // A load slot frees the entry in the same cycle, so a new sample can land behind it.
  assign sample_ready_o = ~hold_full_q | load_now;
  assign accept         = sample_valid_i & sample_ready_o;

  assign x_ext = SumW'(x_q);
  assign fb    = dac_q ? FsVal : -FsVal;

`ifdef DSM2_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dith = lfsr_q[0] ? One : -One;
`else
  assign dith = '0;
`endif

  always_comb begin
    i1_clamp = 1'b0;
    i2_clamp = 1'b0;
    i1_sum   = SumW'(i1_q) + x_ext - fb + dith;
    i1_n     = ACC_W'(sat_acc(64'(i1_sum), ACC_W, i1_clamp));
    i2_sum   = SumW'(i2_q) + SumW'(i1_n) - fb;
    i2_n     = ACC_W'(sat_acc(64'(i2_sum), ACC_W, i2_clamp));
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    x_d         = x_q;
    tick_d      = 1'b0;
    underrun_d  = underrun_q;
    sat_d       = sat_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    dac_d       = dac_q;

    if (load_now) begin
      if (hold_full_q) begin
        x_d         = hold_q;
        hold_full_d = 1'b0;
        tick_d      = 1'b1;
      end else begin
        underrun_d  = 1'b1;
      end
    end

    if (accept) begin
      hold_d      = sample_i;
      hold_full_d = 1'b1;
    end

    if (en_i) begin
      i1_d  = i1_n;
      i2_d  = i2_n;
      dac_d = ~i2_n[ACC_W-1];
      if (i1_clamp || i2_clamp) begin
        sat_d = 1'b1;
      end
    end

    if (clr_flags_i) begin
      underrun_d = 1'b0;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_q         <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      dac_q       <= 1'b0;
      tick_q      <= 1'b0;
      underrun_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      x_q         <= x_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      dac_q       <= dac_d;
      tick_q      <= tick_d;
      underrun_q  <= underrun_d;
      sat_q       <= sat_d;
    end
  end

  assign dac_o         = dac_q;
  assign sample_tick_o = tick_q;
  assign underrun_o    = underrun_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_dsm2_dac_core.sv
// Directed bench for dsm2_dac_core: scoreboard of accepted samples checked against x_reg loads.
module tb_dsm2_dac_core;

  localparam int unsigned DataW = 16;
  localparam int unsigned Osr   = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en_i;
  logic [DataW-1:0] sample_i;
  logic             sample_valid_i;
  logic             clr_flags_i;
  logic             sample_ready_o;
  logic             dac_o;
  logic             sample_tick_o;
  logic             underrun_o;
  logic             sat_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [DataW-1:0] sb[$];
  bit   incr_mode = 1'b0;
  bit   have_tick = 1'b0;
  logic dac_prev  = 1'b0;
  int   n_acc = 0, n_tick = 0, n_same = 0, n_badint = 0, n_ones = 0, n_toggle = 0;
  int   since_tick = 0;

  always #5 clk = ~clk;

  dsm2_dac_core #(
    .DATA_W (DataW),
    .ACC_W  (20),
    .OSR    (Osr)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .dac_o          (dac_o),
    .sample_tick_o  (sample_tick_o),
    .underrun_o     (underrun_o),
    .sat_o          (sat_o),
    .clr_flags_i    (clr_flags_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_total++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d expected in [%0d,%0d]", tag, obs, lo, hi);
  endtask

  // One clock: record a handshake at the coming edge, then observe outputs on the falling edge.
  task automatic cyc();
    bit acc;
    acc = rst_n && sample_valid_i && sample_ready_o;
    if (acc) begin
      sb.push_back(sample_i);
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (acc && incr_mode) sample_i = sample_i + 16'd1;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      have_tick = 1'b0;
    end else begin
      since_tick++;
      if (dac_o) n_ones++;
      if (dac_o != dac_prev) n_toggle++;
      dac_prev = dac_o;
      if (sample_tick_o) begin
        n_tick++;
        if (acc) n_same++;
        if (have_tick && since_tick != Osr) n_badint++;
        since_tick = 0;
        have_tick  = 1'b1;
        if (sb.size() == 0) check("sb_nonempty_on_tick", 32'(sb.size()), 32'd1);
        else check("sb_x_reg", {16'h0, dut.x_q}, {16'h0, sb.pop_front()});
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_ones, s_tick, s_acc, s_same, s_bad, s_tog, lat;
    bit found;

    rst_n = 1'b0; en_i = 1'b1; sample_i = '0; sample_valid_i = 1'b0; clr_flags_i = 1'b0;
    #99;
    check("rst_dac", 32'(dac_o), 32'd0);
    check("rst_ready", 32'(sample_ready_o), 32'd1);
    check("rst_tick", 32'(sample_tick_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    check("rst_sat", 32'(sat_o), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(Osr - 1);
    check("underrun_before_slot", 32'(underrun_o), 32'd0);
    cyc();
    check("underrun_first_slot", 32'(underrun_o), 32'd1);
    check("idle_no_tick", 32'(n_tick), 32'd0);

    // Zero input
    sample_valid_i = 1'b1; sample_i = 16'h0000; clr_flags_i = 1'b1;
    cyc();
    clr_flags_i = 1'b0;
    check("clr_underrun", 32'(underrun_o), 32'd0);
    check("clr_sat", 32'(sat_o), 32'd0);
    run(256);
    s_ones = n_ones; s_tick = n_tick;
    run(4096);
    check_range("zero_ones", n_ones - s_ones, 2040, 2056);
    check("zero_ticks", 32'(n_tick - s_tick), 32'd64);
    check("zero_sat", 32'(sat_o), 32'd0);
    check("zero_underrun", 32'(underrun_o), 32'd0);

    // Half scale
    sample_i = 16'h4000;
    run(512);
    s_ones = n_ones; s_tick = n_tick; s_bad = n_badint;
    run(4096);
    check_range("half_ones", n_ones - s_ones, 3052, 3092);
    check("half_ticks", 32'(n_tick - s_tick), 32'd64);
    check("half_tick_interval", 32'(n_badint - s_bad), 32'd0);
    check("half_sat", 32'(sat_o), 32'd0);

    // Incrementing samples with valid held high
    sample_i = 16'd1; incr_mode = 1'b1;
    run(128);
    s_acc = n_acc; s_same = n_same;
    run(640);
    check("incr_accepts", 32'(n_acc - s_acc), 32'd10);
    check("incr_same_cycle", 32'(n_same - s_same), 32'd10);

    // Enable freeze, starting right after a load so the counter sits at zero
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cyc();
      if (sample_tick_o) found = 1'b1;
    end
    check("freeze_find_tick", 32'(found), 32'd1);
    en_i = 1'b0;
    s_tog = n_toggle; s_tick = n_tick; s_acc = n_acc;
    run(100);
    check("freeze_dac_toggles", 32'(n_toggle - s_tog), 32'd0);
    check("freeze_ticks", 32'(n_tick - s_tick), 32'd0);
    check("freeze_accepts", 32'(n_acc - s_acc), 32'd0);
    en_i = 1'b1;
    found = 1'b0; lat = 0;
    for (int k = 1; k <= 200 && !found; k++) begin
      cyc();
      if (sample_tick_o) begin
        found = 1'b1;
        lat   = k;
      end
    end
    check("resume_latency", 32'(lat), 32'(Osr));

    // Overdrive
    incr_mode = 1'b0; sample_i = 16'h7FFF;
    run(256);
    s_ones = n_ones;
    run(1792);
    check_range("over_ones", n_ones - s_ones, 1703, 1792);
    check("over_sat", 32'(sat_o), 32'd1);
    clr_flags_i = 1'b1;
    cyc();
    clr_flags_i = 1'b0;
    check("clr_prio_sat", 32'(sat_o), 32'd0);
    check("clr_prio_underrun", 32'(underrun_o), 32'd0);

    // Starve, then park one sample in the holding register and reset mid-cycle
    sample_i = 16'h0000; sample_valid_i = 1'b0;
    run(140);
    check("starve_underrun", 32'(underrun_o), 32'd1);
    sample_valid_i = 1'b1;
    cyc();
    sample_valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (dac_o) found = 1'b1;
      else cyc();
    end
    check("pre_reset_dac_high", 32'(found), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_dac", 32'(dac_o), 32'd0);
    check("async_ready", 32'(sample_ready_o), 32'd1);
    check("async_tick", 32'(sample_tick_o), 32'd0);
    check("async_underrun", 32'(underrun_o), 32'd0);
    check("async_sat", 32'(sat_o), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_tick = n_tick;
    run(Osr);
    check("post_reset_underrun", 32'(underrun_o), 32'd1);
    check("post_reset_no_tick", 32'(n_tick - s_tick), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
